// File: rtl/timer_ctrl_if.sv
// Button/switch inputs and datapath control outputs of the timer control FSM.
// The master drives buttons, switch and end flag; the slave is timer_ctrl_unit.
interface timer_ctrl_if;
  logic       btn_run;
  logic       btn_clear;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       sw_down;
  logic       end_flag;
  logic       run_stop;
  logic       clear;
  logic       down;
  logic       hour_up;
  logic       hour_down;
  logic       min_up;
  logic       min_down;
  logic       sec_up;
  logic       sec_down;
  logic [1:0] field;
  logic       edit;
  logic       alarm;

  modport master (
    output btn_run, btn_clear, btn_mode, btn_up, btn_down, sw_down, end_flag,
    input  run_stop, clear, down, hour_up, hour_down, min_up, min_down,
           sec_up, sec_down, field, edit, alarm
  );

  modport slave (
    input  btn_run, btn_clear, btn_mode, btn_up, btn_down, sw_down, end_flag,
    output run_stop, clear, down, hour_up, hour_down, min_up, min_down,
           sec_up, sec_down, field, edit, alarm
  );
endinterface

// File: rtl/timer_ctrl_unit.sv
// Timer control FSM: turns button pulses into run/clear/direction/edit controls.
// Optional alarm auto-timeout enabled by defining TIMER_ALARM_TIMEOUT_EN.
module timer_ctrl_unit
`ifdef TIMER_ALARM_TIMEOUT_EN
  #(parameter int unsigned ALARM_CYCLES = 500_000_000)
`endif
  (
  input logic         clk,
  input logic         rst_n,
  timer_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SET   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_ALARM = 3'd4;

  logic [2:0] state;
  logic [2:0] state_n;
  logic [1:0] field_n;
  logic       down_n;
  logic       clear_n;
  logic [5:0] pulse_n;  // {hour_up, hour_down, min_up, min_down, sec_up, sec_down}

`ifdef TIMER_ALARM_TIMEOUT_EN
  localparam int unsigned CNT_W = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  logic [CNT_W-1:0] alarm_cnt;
  logic             alarm_done;

  assign alarm_done = (alarm_cnt == CNT_W'(ALARM_CYCLES - 1));

  // Counts cycles spent in ALARM; zero on every entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alarm_cnt <= '0;
    end else if (state == S_ALARM && state_n == S_ALARM) begin
      alarm_cnt <= alarm_cnt + CNT_W'(1);
    end else begin
      alarm_cnt <= '0;
    end
  end
`endif

  // Next state and next registered outputs; Clear > Run > Mode > Up/Down.
  always_comb begin
    state_n = state;
    field_n = bus.field;
    down_n  = bus.down;
    clear_n = 1'b0;
    pulse_n = 6'b0;
    if (bus.btn_clear) begin
      state_n = S_IDLE;
      clear_n = 1'b1;
      field_n = 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          down_n = bus.sw_down;
          if (bus.btn_run) begin
            if (!(bus.sw_down && bus.end_flag)) state_n = S_RUN;
          end else if (bus.btn_mode) begin
            state_n = S_SET;
            field_n = 2'd0;
          end
        end
        S_SET: begin
          down_n = bus.sw_down;
          if (bus.btn_run) begin
            if (!(bus.sw_down && bus.end_flag)) state_n = S_RUN;
          end else if (bus.btn_mode) begin
            if (bus.field == 2'd2) begin
              state_n = S_IDLE;
              field_n = 2'd0;
            end else begin
              field_n = bus.field + 2'd1;
            end
          end else if (bus.btn_up ^ bus.btn_down) begin
            case (bus.field)
              2'd0:    pulse_n = bus.btn_up ? 6'b000010 : 6'b000001;
              2'd1:    pulse_n = bus.btn_up ? 6'b001000 : 6'b000100;
              2'd2:    pulse_n = bus.btn_up ? 6'b100000 : 6'b010000;
              default: pulse_n = 6'b0;
            endcase
          end
        end
        S_RUN: begin
          if (bus.btn_run) begin
            state_n = S_PAUSE;
          end else if (bus.down && bus.end_flag) begin
            state_n = S_ALARM;
          end
        end
        S_PAUSE: begin
          if (bus.btn_run) begin
            if (!(bus.down && bus.end_flag)) state_n = S_RUN;
          end else if (bus.btn_mode) begin
            state_n = S_SET;
            field_n = 2'd0;
          end
        end
        S_ALARM: begin
          if (bus.btn_run || bus.btn_mode || bus.btn_up || bus.btn_down) begin
            state_n = S_IDLE;
          end
`ifdef TIMER_ALARM_TIMEOUT_EN
          else if (alarm_done) begin
            state_n = S_IDLE;
          end
`endif
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State and all outputs registered together; status levels follow next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      bus.run_stop  <= 1'b0;
      bus.clear     <= 1'b0;
      bus.down      <= 1'b0;
      bus.field     <= 2'd0;
      bus.edit      <= 1'b0;
      bus.alarm     <= 1'b0;
      bus.hour_up   <= 1'b0;
      bus.hour_down <= 1'b0;
      bus.min_up    <= 1'b0;
      bus.min_down  <= 1'b0;
      bus.sec_up    <= 1'b0;
      bus.sec_down  <= 1'b0;
    end else begin
      state         <= state_n;
      bus.run_stop  <= (state_n == S_RUN);
      bus.edit      <= (state_n == S_SET);
      bus.alarm     <= (state_n == S_ALARM);
      bus.clear     <= clear_n;
      bus.down      <= down_n;
      bus.field     <= field_n;
      bus.hour_up   <= pulse_n[5];
      bus.hour_down <= pulse_n[4];
      bus.min_up    <= pulse_n[3];
      bus.min_down  <= pulse_n[2];
      bus.sec_up    <= pulse_n[1];
      bus.sec_down  <= pulse_n[0];
    end
  end

endmodule
